edge_rate_filter: RTL and testbench
===================================

Name: edge_rate_filter

Overview:
Front-end stage of the clock-recovery path, directly upstream of the lock-in limit filter. It synchronises the raw recovered-data line and detects both edges. It measures the cycle count between accepted edges against the configured half-rate band and rejects glitch edges. It produces the live rate counter and the filtered-event pulse that the lock-in stage consumes.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw_i (legal range 2..4)
COUNTER_WIDTH, clks_alot_p::COUNTER_WIDTH, width of the rate counter and interval outputs

Ports:
sys_dom_i  input  common_p::clk_dom_s  clock-domain bundle: single rising-edge clock; reset is asynchronous, active-low
recovery_en_i  input  1  enables measurement; low forces IDLE
half_rate_limits_i  input  clks_alot_p::half_rate_limits_s  uses minimum_band_minus_one and maximum_band_minus_one
raw_i  input  1  asynchronous raw data/clock line
current_rate_counter_o  output  COUNTER_WIDTH  live cycles-since-last-accepted-edge counter
filtered_event_o  output  1  one-cycle pulse per accepted edge
last_interval_o  output  COUNTER_WIDTH  counter value captured at the last accepted edge
glitch_o  output  1  one-cycle pulse per rejected edge
stall_o  output  1  high while in STALLED
locked_o  output  1  high while in TRACK

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, state IDLE, counter 0.
- Synchroniser: raw_i passes through SYNC_STAGES flops. Edge = last stage XOR a registered copy of it. Both polarities count.
- Edge latency: filtered_event_o/glitch_o assert SYNC_STAGES+1 clocks after the first clock that samples the new raw level.
- Counter rule:
  - Accepted edge: counter <= 0.
  - Otherwise, in any non-IDLE state: counter <= counter+1, saturating at all-ones (no wrap).
- States:
  - IDLE:
    - counter held 0; edges ignored; outputs 0.
    - recovery_en_i rising -> ACQUIRE.
  - ACQUIRE:
    - the first edge is accepted unconditionally: pulse filtered_event_o, last_interval_o unchanged, -> TRACK.
  - TRACK:
    - edge with counter >= minimum_band_minus_one: accepted; last_interval_o <= counter; pulse filtered_event_o.
    - edge with counter below the minimum: rejected; pulse glitch_o; counter keeps counting.
    - no edge and counter > maximum_band_minus_one: -> STALLED.
  - STALLED:
    - stall_o=1.
    - next edge accepted unconditionally (resync): last_interval_o unchanged; -> TRACK.
- recovery_en_i low in any state: -> IDLE next clock. Counter, last_interval_o, glitch/event/stall/locked all cleared. The synchroniser keeps running.
- Saturation: a maximum_band_minus_one of all-ones never stalls. The saturated counter stays at all-ones until an edge arrives.
- Simultaneous events:
  - edge arriving on the cycle the stall condition becomes true: the edge wins (accept/reject rule applies), no stall.
  - recovery_en_i falling on the same cycle as an edge: disable wins, no pulse.
- Limits are sampled combinationally every cycle. Changes take effect immediately with no re-acquisition.
- Asynchronous reset mid-operation: everything returns to reset values immediately; normal operation resumes on the first clock after release.

Decomposition:
- clks_alot_p: add the state enum edge_rate_state_e (IDLE, ACQUIRE, TRACK, STALLED) and a SYNC_STAGES_DEFAULT constant. half_rate_limits_s and COUNTER_WIDTH are reused from there.
- Sub-module: a small sync_edge_detect (N-flop synchroniser plus both-edge detector, outputs synced level and edge pulse), instantiated once.

Test Plan:
Common config: SYNC_STAGES=2, COUNTER_WIDTH=8, minimum_band_minus_one=3, maximum_band_minus_one=9.
1. Reset held, raw_i toggling -> all outputs 0. After release with recovery_en_i=0 -> still 0, counter 0.
2. recovery_en_i=1, raw_i toggles every 6 clocks:
   - first edge: filtered_event_o 3 clocks after sampling, locked_o=1.
   - each later edge: filtered_event_o every 6 clocks, last_interval_o=5, counter returns to 0.
3. In TRACK, 2-clock high glitch -> leading edge accepted (last_interval_o=5); trailing edge gives glitch_o pulse only, counter continues 2,3,...
4. Stop toggling -> counter reaches 10, stall_o=1, locked_o=0. Next edge: filtered_event_o pulse, stall_o=0, last_interval_o holds the previous value, counter 0.
5. Drop recovery_en_i mid-TRACK, coincident with an edge -> no filtered_event_o; next clock all outputs 0; later edges ignored.
6. Set maximum_band_minus_one=255 and stop toggling -> counter saturates at 255, stall_o stays 0. Assert reset mid-count -> outputs clear immediately.

Source files
------------

// File: rtl/clks_alot_p.sv
// Shared types and constants for the clock-recovery path: rate-counter width,
// half-rate band limits, and the edge_rate_filter state encoding.
package clks_alot_p;

  localparam int COUNTER_WIDTH       = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Both limits are stored as "band minus one" so a rate counter that starts
  // at zero on an accepted edge can be compared against them directly.
  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] minimum_band_minus_one;
    logic [COUNTER_WIDTH-1:0] maximum_band_minus_one;
  } half_rate_limits_s;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    STALLED = 2'd3
  } edge_rate_state_e;

endpackage : clks_alot_p

// File: rtl/common_p.sv
// Common clock-domain bundle shared by the clock-recovery blocks.
// clk_dom_s carries one rising-edge clock and its asynchronous active-low reset.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage : common_p

// File: rtl/sync_edge_detect.sv
// N-flop synchroniser followed by a both-polarity edge detector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   raw_i      : asynchronous input line
//   level_o    : synchronised level (last synchroniser stage)
//   edge_o     : registered one-cycle pulse on every level change
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    level_d = sync_q[SYNC_STAGES-1];
    // The pulse is registered so downstream logic sees a clean flop output;
    // this adds one clock to the edge latency.
    edge_d  = sync_q[SYNC_STAGES-1] ^ level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = edge_q;

endmodule : sync_edge_detect

// File: rtl/edge_rate_filter.sv
// Front end of the clock-recovery path. Synchronises raw_i, detects both
// edges, measures the interval between accepted edges against the half-rate
// band and rejects edges that arrive too early (glitches).
// Ports:
//   sys_dom_i              : clock / async active-low reset bundle
//   recovery_en_i          : measurement enable; low forces IDLE
//   half_rate_limits_i     : minimum/maximum band limits (minus one)
//   raw_i                  : asynchronous recovered data/clock line
//   current_rate_counter_o : cycles since the last accepted edge (saturating)
//   filtered_event_o       : one-cycle pulse per accepted edge
//   last_interval_o        : counter value captured at the last accepted edge
//   glitch_o               : one-cycle pulse per rejected edge
//   stall_o                : high while STALLED
//   locked_o               : high while TRACK
module edge_rate_filter
  import clks_alot_p::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
  input  common_p::clk_dom_s        sys_dom_i,
  input  logic                      recovery_en_i,
  input  half_rate_limits_s         half_rate_limits_i,
  input  logic                      raw_i,
  output logic [COUNTER_WIDTH-1:0]  current_rate_counter_o,
  output logic                      filtered_event_o,
  output logic [COUNTER_WIDTH-1:0]  last_interval_o,
  output logic                      glitch_o,
  output logic                      stall_o,
  output logic                      locked_o
);

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  logic sync_level;
  logic edge_pulse;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (raw_i),
    .level_o(sync_level),
    .edge_o (edge_pulse)
  );

  edge_rate_state_e         state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0] last_interval_q, last_interval_d;
  logic                     filtered_event_q, filtered_event_d;
  logic                     glitch_q, glitch_d;
  logic                     en_q, en_d;

  logic [COUNTER_WIDTH-1:0] min_band;
  logic [COUNTER_WIDTH-1:0] max_band;
  logic [COUNTER_WIDTH-1:0] counter_inc;

  assign min_band    = COUNTER_WIDTH'(half_rate_limits_i.minimum_band_minus_one);
  assign max_band    = COUNTER_WIDTH'(half_rate_limits_i.maximum_band_minus_one);
  // Saturate rather than wrap so a dead line never looks like a fresh edge.
  assign counter_inc = (counter_q == '1) ? counter_q : counter_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    counter_d        = counter_q;
    last_interval_d  = last_interval_q;
    filtered_event_d = 1'b0;
    glitch_d         = 1'b0;
    en_d             = recovery_en_i;

    if (!recovery_en_i) begin
      // Disable overrides everything, including an edge on the same cycle.
      state_d         = IDLE;
      counter_d       = '0;
      last_interval_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          counter_d = '0;
          if (!en_q) state_d = ACQUIRE;
        end
        ACQUIRE, STALLED: begin
          // No reference interval exists yet (or it was lost): take the
          // next edge unconditionally without updating last_interval.
          if (edge_pulse) begin
            filtered_event_d = 1'b1;
            counter_d        = '0;
            state_d          = TRACK;
          end else begin
            counter_d = counter_inc;
          end
        end
        TRACK: begin
          if (edge_pulse) begin
            if (counter_q >= min_band) begin
              filtered_event_d = 1'b1;
              last_interval_d  = counter_q;
              counter_d        = '0;
            end else begin
              glitch_d  = 1'b1;
              counter_d = counter_inc;
            end
          end else begin
            counter_d = counter_inc;
            // An edge on this cycle takes priority, so the stall test lives
            // only in the no-edge branch. Saturated counter with an all-ones
            // maximum never exceeds it, so that setting never stalls.
            if (counter_q > max_band) state_d = STALLED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      counter_q        <= '0;
      last_interval_q  <= '0;
      filtered_event_q <= 1'b0;
      glitch_q         <= 1'b0;
      en_q             <= 1'b0;
    end else begin
      state_q          <= state_d;
      counter_q        <= counter_d;
      last_interval_q  <= last_interval_d;
      filtered_event_q <= filtered_event_d;
      glitch_q         <= glitch_d;
      en_q             <= en_d;
    end
  end

  assign current_rate_counter_o = counter_q;
  assign filtered_event_o       = filtered_event_q;
  assign last_interval_o        = last_interval_q;
  assign glitch_o               = glitch_q;
  assign stall_o                = (state_q == STALLED);
  assign locked_o               = (state_q == TRACK);

endmodule : edge_rate_filter

// File: tb/tb_edge_rate_filter.sv
// Scoreboard bench for edge_rate_filter: directed raw_i patterns push the
// expected pulse (kind + last_interval) into a queue; a negedge monitor pops
// and compares whenever the DUT pulses filtered_event_o or glitch_o.
module tb_edge_rate_filter;

  logic                           clk;
  logic                           rst_n;
  common_p::clk_dom_s             sys_dom;
  logic                           recovery_en;
  clks_alot_p::half_rate_limits_s limits;
  logic                           raw;
  logic [7:0]                     counter;
  logic                           filtered_event;
  logic [7:0]                     last_interval;
  logic                           glitch;
  logic                           stall;
  logic                           locked;

  assign sys_dom = {clk, rst_n};

  edge_rate_filter #(
    .SYNC_STAGES  (2),
    .COUNTER_WIDTH(8)
  ) dut (
    .sys_dom_i             (sys_dom),
    .recovery_en_i         (recovery_en),
    .half_rate_limits_i    (limits),
    .raw_i                 (raw),
    .current_rate_counter_o(counter),
    .filtered_event_o      (filtered_event),
    .last_interval_o       (last_interval),
    .glitch_o              (glitch),
    .stall_o               (stall),
    .locked_o              (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_glitch;
    int last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_glitch, input int last);
    exp_t e;
    e.is_glitch = is_glitch;
    e.last      = last;
    sb.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_counter"}, int'(counter), 0);
    chk({tag, "_event"},   int'(filtered_event), 0);
    chk({tag, "_last"},    int'(last_interval), 0);
    chk({tag, "_glitch"},  int'(glitch), 0);
    chk({tag, "_stall"},   int'(stall), 0);
    chk({tag, "_locked"},  int'(locked), 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (filtered_event || glitch) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_item = sb.pop_front();
        chk("pulse_kind", int'(glitch), int'(mon_item.is_glitch));
        chk("pulse_event_bit", int'(filtered_event), int'(!mon_item.is_glitch));
        chk("pulse_last_interval", int'(last_interval), mon_item.last);
        if (!mon_item.is_glitch) chk("accept_counter_zero", int'(counter), 0);
        $display("txn %s last_interval=%0d counter=%0d",
                 glitch ? "glitch" : "event", last_interval, counter);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    recovery_en = 1'b0;
    raw         = 1'b0;
    limits.minimum_band_minus_one = 8'd3;
    limits.maximum_band_minus_one = 8'd9;

    // 1. Reset held with raw toggling, then released with enable low.
    for (int i = 0; i < 6; i++) begin
      raw = ~raw;
      tick(1);
    end
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    tick(5);
    chk_all_zero("idle");

    // 2. Enable and toggle every 6 clocks.
    recovery_en = 1'b1;
    tick(2);
    push_exp(1'b0, 0);
    raw = ~raw;
    tick(3);
    chk("first_latency_early", int'(filtered_event), 0);
    tick(1);
    chk("first_latency_event", int'(filtered_event), 1);
    chk("first_locked", int'(locked), 1);
    chk("first_last_unchanged", int'(last_interval), 0);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, 5);
      raw = ~raw;
      tick(4);
      chk("track_counter_zero", int'(counter), 0);
      chk("track_last_interval", int'(last_interval), 5);
      tick(2);
    end

    // 3. Two-clock high glitch: leading edge accepted, trailing edge rejected.
    push_exp(1'b0, 5);
    raw = ~raw;
    tick(2);
    push_exp(1'b1, 5);
    raw = ~raw;
    tick(4);
    chk("glitch_pulse", int'(glitch), 1);
    chk("glitch_counter", int'(counter), 2);
    tick(1);
    chk("glitch_counter_next", int'(counter), 3);
    chk("glitch_cleared", int'(glitch), 0);

    // 4. Stop toggling until stalled, then resync.
    tick(7);
    chk("pre_stall_counter", int'(counter), 10);
    chk("pre_stall_stall", int'(stall), 0);
    chk("pre_stall_locked", int'(locked), 1);
    tick(1);
    chk("stall_high", int'(stall), 1);
    chk("stall_unlocked", int'(locked), 0);
    push_exp(1'b0, 5);
    raw = ~raw;
    tick(4);
    chk("resync_stall_low", int'(stall), 0);
    chk("resync_locked", int'(locked), 1);
    chk("resync_counter", int'(counter), 0);
    chk("resync_last_held", int'(last_interval), 5);

    // 5. Disable coincident with an acceptable edge.
    raw = ~raw;
    tick(3);
    recovery_en = 1'b0;
    tick(1);
    chk_all_zero("disable");
    raw = ~raw;
    tick(6);
    chk_all_zero("disabled_edges");

    // 6. All-ones maximum never stalls; counter saturates; async reset.
    limits.maximum_band_minus_one = 8'd255;
    recovery_en = 1'b1;
    tick(2);
    push_exp(1'b0, 0);
    raw = ~raw;
    tick(4);
    chk("reacq_locked", int'(locked), 1);
    tick(2);
    push_exp(1'b0, 5);
    raw = ~raw;
    tick(4);
    chk("reacq_last", int'(last_interval), 5);
    tick(260);
    chk("sat_counter", int'(counter), 255);
    chk("sat_no_stall", int'(stall), 0);
    chk("sat_locked", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    recovery_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk_all_zero("post_reset");

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_edge_rate_filter
